// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Pop-side adapter for a fifo1r1w instance. It drains the FIFO through its
// ren/rdata/empty port and presents the data as a valid/ready stream. A
// 2-entry output buffer (head e0 plus skid e1) sustains one beat per cycle.
// There is no combinational path from m_ready to fifo_ren.
//
// Parameters:
//   DWID        data width, must match the attached FIFO
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous discard of the buffered entries
//   fifo_empty  FIFO empty flag (registered inside the FIFO)
//   fifo_rdata  FIFO head data, valid whenever fifo_empty is low
//   fifo_ren    FIFO pop strobe, head is consumed at the rising edge
//   m_valid     stream data valid
//   m_ready     consumer accepts the current beat
//   m_data      stream data
//   beat_cnt    16-bit accepted-beat counter (only with FIFO_RD_CNT_EN)
//
// Optional feature macro: FIFO_RD_CNT_EN adds the beat_cnt port and counter.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int DWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            fifo_empty,
    input  logic [DWID-1:0] fifo_rdata,
    output logic            fifo_ren,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DWID-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]     beat_cnt
`endif
);

    // Occupancy encoding doubles as the state: EMPTY/ONE/TWO = number of
    // buffered entries.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]      cnt;
    logic [DWID-1:0] e0;
    logic [DWID-1:0] e1;
    logic            push;
    logic            pop;

    assign m_valid = (cnt != ST_EMPTY);
    assign m_data  = e0;
    assign pop     = m_valid & m_ready;

    // The pop strobe looks only at registered occupancy, the FIFO flag and
    // flush, never at m_ready. Because there is always room for one more
    // entry whenever cnt < 2, a stall can absorb at most one extra word.
    // rst_n is included so no entry is consumed while reset is held.
    assign fifo_ren = ~fifo_empty & ~flush & (cnt < ST_TWO) & rst_n;
    assign push     = fifo_ren;

    // Buffer state machine. A flush empties the buffer regardless of a
    // concurrent push/pop (push is already suppressed by flush). In ONE with
    // simultaneous push and pop the new word replaces the head directly, which
    // keeps the skid register idle during steady streaming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= ST_EMPTY;
            e0  <= '0;
            e1  <= '0;
        end else if (flush) begin
            cnt <= ST_EMPTY;
        end else begin
            case (cnt)
                ST_EMPTY: begin
                    if (push) begin
                        e0  <= fifo_rdata;
                        cnt <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        e0 <= fifo_rdata;
                    end else if (push) begin
                        e1  <= fifo_rdata;
                        cnt <= ST_TWO;
                    end else if (pop) begin
                        cnt <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        e0  <= e1;
                        cnt <= ST_ONE;
                    end
                end
                default: begin
                    cnt <= ST_EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] beat_q;

    // Counts every accepted beat, including one accepted during a flush
    // cycle. Only reset clears it; it wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else if (pop) begin
            beat_q <= beat_q + 16'd1;
        end
    end

    assign beat_cnt = beat_q;
`endif

endmodule
